// File: rtl/el2_pkg.sv
// el2_pkg -- shared types for the instruction trace sink.
//
// Contents:
//   el2_trace_pkt_t         per-retire trace packet produced by the core (104 bits)
//   el2_trace_entry_t       what the sink keeps per queued packet
//   el2_trace_hdr_t         layout of the framed header word
//   el2_trace_sink_state_t  serializer FSM states
//   make_entry / hdr_word   packing helpers
//
// Optional feature macro: EL2_TRACE_TVAL_EN
//   defined   -> entries keep tval (104-bit entry) and exception/interrupt
//                packets carry a fourth TVAL word
//   undefined -> entries are 72 bits, no TVAL word, no TVAL state
package el2_pkg;

  typedef struct packed {
    logic [31:0] trace_rv_i_insn_ip;
    logic [31:0] trace_rv_i_address_ip;
    logic        trace_rv_i_valid_ip;
    logic        trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic        trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
  } el2_trace_pkt_t;

  // tval_present is resolved at capture so the serializer never has to
  // re-derive it from the cause bits.
  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] addr;
`ifdef EL2_TRACE_TVAL_EN
    logic [31:0] tval;
`endif
    logic        interrupt;
    logic        exception;
    logic [4:0]  ecause;
    logic        tval_present;
  } el2_trace_entry_t;

  localparam int TRACE_ENTRY_W = $bits(el2_trace_entry_t);

  typedef struct packed {
    logic       interrupt;
    logic       exception;
    logic [4:0] ecause;
    logic       tval_present;
    logic [7:0] drop_cnt;
    logic [7:0] rsvd;
    logic [7:0] seq;
  } el2_trace_hdr_t;

  localparam int HDR_DROP_LSB = 16;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    INSN,
`ifdef EL2_TRACE_TVAL_EN
    ADDR,
    TVAL
`else
    ADDR
`endif
  } el2_trace_sink_state_t;

  function automatic el2_trace_entry_t make_entry(el2_trace_pkt_t p);
    el2_trace_entry_t e;
    e.insn      = p.trace_rv_i_insn_ip;
    e.addr      = p.trace_rv_i_address_ip;
    e.interrupt = p.trace_rv_i_interrupt_ip;
    e.exception = p.trace_rv_i_exception_ip;
    e.ecause    = p.trace_rv_i_ecause_ip;
`ifdef EL2_TRACE_TVAL_EN
    e.tval         = p.trace_rv_i_tval_ip;
    e.tval_present = p.trace_rv_i_exception_ip | p.trace_rv_i_interrupt_ip;
`else
    e.tval_present = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [31:0] hdr_word(el2_trace_entry_t e, logic [7:0] drop,
                                           logic [7:0] seq);
    el2_trace_hdr_t h;
    h.interrupt    = e.interrupt;
    h.exception    = e.exception;
    h.ecause       = e.ecause;
    h.tval_present = e.tval_present;
    h.drop_cnt     = drop;
    h.rsvd         = 8'h00;
    h.seq          = seq;
    return h;
  endfunction

endpackage

// File: rtl/el2_trace_fifo.sv
// el2_trace_fifo -- small synchronous FIFO holding captured trace entries.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write an entry (caller guarantees space or a same-cycle pop)
//   pop             drop the head entry (caller guarantees not empty)
//   head_data       entry at the head, read in place (combinational)
//   second_data     entry behind the head, needed when the head is popped
//                   and the next packet header must be formed in the same cycle
//   count           number of entries held
//   full, empty     status
//
// DEPTH must be a power of two (pointers wrap naturally), minimum 2.
module el2_trace_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [WIDTH-1:0]         second_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;

  // Storage carries no reset; only the pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data   = mem[rd_ptr_reg];
  assign second_data = mem[rd_ptr_reg + AW'(1)];
  assign count       = count_reg;
  assign full        = (count_reg == CW'(DEPTH));
  assign empty       = (count_reg == '0);

endmodule

// File: rtl/el2_trace_sink.sv
// el2_trace_sink -- consumer of the core's per-retire trace packets.
//
// Captures valid packets into a FIFO and serializes each as framed 32-bit
// words HDR, INSN, ADDR [, TVAL] on a valid/ready stream. Packets arriving
// with no room are dropped and counted; the count rides in the next header.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   trace_en     capture enable (disabled packets are neither queued nor counted)
//   trace_pkt    trace packet, qualified by trace_rv_i_valid_ip
//   out_valid    stream word valid
//   out_data     stream word
//   out_last     final word of the current packet
//   out_ready    downstream accept
//   drop_cnt     saturating drop count since the last accepted header
//   fifo_empty   FIFO holds no entries
//
// Optional feature macro: EL2_TRACE_TVAL_EN (TVAL word for exception/interrupt
// packets). Without it the TVAL state and the tval storage are not built.
module el2_trace_sink
  import el2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           trace_en,
  input  el2_trace_pkt_t trace_pkt,
  output logic           out_valid,
  output logic [31:0]    out_data,
  output logic           out_last,
  input  logic           out_ready,
  output logic [7:0]     drop_cnt,
  output logic           fifo_empty
);

  localparam int CW = $clog2(DEPTH) + 1;

  el2_trace_sink_state_t state_reg;
  logic                  out_valid_reg;
  logic [31:0]           out_data_reg;
  logic                  out_last_reg;
  logic [7:0]            seq_reg;
  logic [7:0]            drop_cnt_reg;
  logic [7:0]            drop_cnt_next;

  el2_trace_entry_t in_entry;
  el2_trace_entry_t head_entry;
  el2_trace_entry_t second_entry;
  el2_trace_entry_t hdr_entry;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;

  logic push_req;
  logic push_accept;
  logic drop;
  logic handshake;
  logic pkt_done;
  logic hdr_accept;
  logic more;
  logic hdr_load;

`ifndef EL2_TRACE_TVAL_EN
  logic unused_tval;
  assign unused_tval = ^trace_pkt.trace_rv_i_tval_ip;
`endif

  assign in_entry    = make_entry(trace_pkt);
  assign push_req    = trace_en & trace_pkt.trace_rv_i_valid_ip;
  assign handshake   = out_valid_reg & out_ready;
  // The last word of a packet is the only thing that pops the FIFO.
  assign pkt_done    = handshake & out_last_reg;
  assign push_accept = push_req & (~fifo_full | pkt_done);
  assign drop        = push_req & ~push_accept;
  assign hdr_accept  = handshake & (state_reg == HDR);
  // Entries left after this cycle's pop, counting a same-cycle push.
  assign more        = (fifo_count > CW'(1)) | push_accept;

  el2_trace_fifo #(
    .WIDTH (TRACE_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push_accept),
    .push_data   (in_entry),
    .pop         (pkt_done),
    .head_data   (head_entry),
    .second_data (second_entry),
    .count       (fifo_count),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  // Header accept clears the count; a drop in the same cycle then counts as 1.
  always_comb begin
    drop_cnt_next = hdr_accept ? 8'h00 : drop_cnt_reg;
    if (drop && (drop_cnt_next != 8'hFF)) begin
      drop_cnt_next = drop_cnt_next + 8'h01;
    end
  end

  // A header is loaded either from IDLE (bypassing the FIFO when it is empty
  // so the header shows one cycle after the push) or straight after the last
  // word of the previous packet, giving back-to-back packets.
  always_comb begin
    hdr_load  = 1'b0;
    hdr_entry = head_entry;
    if (state_reg == IDLE) begin
      hdr_load  = ~fifo_empty | push_accept;
      hdr_entry = fifo_empty ? in_entry : head_entry;
    end else begin
      hdr_load  = pkt_done & more;
      hdr_entry = (fifo_count > CW'(1)) ? second_entry : in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      out_data_reg  <= 32'h0;
      out_last_reg  <= 1'b0;
      seq_reg       <= 8'h00;
      drop_cnt_reg  <= 8'h00;
    end else begin
      drop_cnt_reg <= drop_cnt_next;
      if (hdr_load) begin
        state_reg     <= HDR;
        out_valid_reg <= 1'b1;
        out_data_reg  <= hdr_word(hdr_entry, drop_cnt_next, seq_reg);
        out_last_reg  <= 1'b0;
      end else begin
        case (state_reg)
          HDR: begin
            if (out_ready) begin
              state_reg    <= INSN;
              out_data_reg <= head_entry.insn;
              seq_reg      <= seq_reg + 8'h01;
            end else begin
              // The drop field must show the live count at the moment the
              // header is accepted, so it keeps tracking while stalled.
              out_data_reg[HDR_DROP_LSB +: 8] <= drop_cnt_next;
            end
          end
          INSN: begin
            if (out_ready) begin
              state_reg    <= ADDR;
              out_data_reg <= head_entry.addr;
              out_last_reg <= ~head_entry.tval_present;
            end
          end
          ADDR: begin
            if (out_ready) begin
`ifdef EL2_TRACE_TVAL_EN
              if (head_entry.tval_present) begin
                state_reg    <= TVAL;
                out_data_reg <= head_entry.tval;
                out_last_reg <= 1'b1;
              end else begin
                state_reg     <= IDLE;
                out_valid_reg <= 1'b0;
                out_data_reg  <= 32'h0;
                out_last_reg  <= 1'b0;
              end
`else
              state_reg     <= IDLE;
              out_valid_reg <= 1'b0;
              out_data_reg  <= 32'h0;
              out_last_reg  <= 1'b0;
`endif
            end
          end
`ifdef EL2_TRACE_TVAL_EN
          TVAL: begin
            if (out_ready) begin
              state_reg     <= IDLE;
              out_valid_reg <= 1'b0;
              out_data_reg  <= 32'h0;
              out_last_reg  <= 1'b0;
            end
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign drop_cnt  = drop_cnt_reg;

endmodule
